// File: rtl/cache_arb_pkg.sv
// Shared types for the cache/memory bus arbiter: FSM states, requester ids and
// the transaction tag layout {requester id, slot}.
package cache_arb_pkg;

    localparam int ARB_LOGOUTSTANDING = 2;

    localparam logic REQ_INSTR = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WDATA
    } arb_state_t;

    typedef struct packed {
        logic                          id;
        logic [ARB_LOGOUTSTANDING-1:0] slot;
    } tag_t;

endpackage

// File: rtl/cache_arb_tag_pool.sv
// Per-requester tag slot bitmap: hands out the lowest free slot and accepts a
// mask of slots to release. Allocation always sees the bitmap before frees.
module cache_arb_tag_pool
    import cache_arb_pkg::*;
#(
    parameter int LOGOUTSTANDING = ARB_LOGOUTSTANDING
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             alloc,
    input  logic [(1<<LOGOUTSTANDING)-1:0]   free_mask,
    output logic [LOGOUTSTANDING-1:0]        alloc_slot,
    output logic [(1<<LOGOUTSTANDING)-1:0]   busy,
    output logic                             full
);

    localparam int NSLOT = 1 << LOGOUTSTANDING;

    // Scan from the top so the lowest free index wins.
    always_comb begin
        alloc_slot = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_slot = LOGOUTSTANDING'(i);
            end
        end
    end

    assign full = &busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy & ~free_mask;
            if (alloc && !full) begin
                busy[alloc_slot] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin memory bus arbiter for the I-cache and D-cache miss paths.
// Optional CACHE_ARB_TAGCHECK_EN drops responses to unallocated/write tags and flags err_stray.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int LOGLINESIZE    = 3,
    parameter int LOGOUTSTANDING = ARB_LOGOUTSTANDING
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    req_valid,
    input  logic [1:0]                    req_write,
    input  logic [1:0][WIDTH-1:0]         req_addr,
    output logic [1:0]                    req_ready,
    input  logic [1:0][WIDTH-1:0]         req_wdata,
    output logic [1:0]                    wbeat_ready,
    output logic [LOGLINESIZE-1:0]        wbeat_idx,
    output logic [1:0]                    resp_valid,
    output logic [WIDTH-1:0]              resp_data,
    output logic                          resp_last,
    output logic                          bus_req,
    input  logic                          bus_reqack,
    output logic [LOGOUTSTANDING:0]       bus_reqtag,
    output logic [WIDTH-1:0]              bus_reqaddr,
    output logic                          bus_reqwrite,
    output logic [WIDTH-1:0]              bus_reqdata,
    input  logic                          bus_resp,
    input  logic [LOGOUTSTANDING:0]       bus_resptag,
    input  logic [WIDTH-1:0]              bus_respdata,
    output logic                          bus_respack,
    output logic                          err_stray
);

    localparam int TW    = LOGOUTSTANDING + 1;
    localparam int NSLOT = 1 << LOGOUTSTANDING;
    localparam int NTAG  = 1 << TW;
    localparam logic [LOGLINESIZE-1:0] LAST_BEAT = {LOGLINESIZE{1'b1}};
    localparam logic [WIDTH-1:0] LINE_MASK = {{(WIDTH-LOGLINESIZE){1'b1}}, {LOGLINESIZE{1'b0}}};

    arb_state_t               state;
    logic                     last_grant;
    tag_t                     cur_tag;
    logic [WIDTH-1:0]         cur_addr;
    logic                     cur_write;
    logic                     bus_req_q;
    logic [LOGLINESIZE-1:0]   wbeat_cnt;

    logic [1:0]                      eligible;
    logic [1:0]                      full;
    logic [1:0][NSLOT-1:0]           busy;
    logic [1:0][LOGOUTSTANDING-1:0]  alloc_slot;
    logic [1:0][NSLOT-1:0]           free_mask;
    logic                            grant_valid;
    logic                            grant_id;
    logic                            in_wdata;

    tag_t                            rtag;
    logic [NTAG-1:0][LOGLINESIZE-1:0] rbeat;
    logic                            tag_known;
    logic                            resp_take;
    logic                            resp_last_beat;

    assign eligible = req_valid & ~full;

    // On a tie, the requester not granted last time goes first.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = REQ_INSTR;
        if (!reset && state == IDLE) begin
            if (&eligible) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (eligible[REQ_INSTR]) begin
                grant_valid = 1'b1;
                grant_id    = REQ_INSTR;
            end else if (eligible[REQ_DATA]) begin
                grant_valid = 1'b1;
                grant_id    = REQ_DATA;
            end
        end
    end

    assign req_ready = {grant_valid & grant_id, grant_valid & ~grant_id};

    for (genvar k = 0; k < 2; k++) begin : g_pool
        cache_arb_tag_pool #(
            .LOGOUTSTANDING(LOGOUTSTANDING)
        ) u_pool (
            .clk       (clk),
            .reset     (reset),
            .alloc     (req_ready[k]),
            .free_mask (free_mask[k]),
            .alloc_slot(alloc_slot[k]),
            .busy      (busy[k]),
            .full      (full[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_tag    <= '0;
            cur_addr   <= '0;
            cur_write  <= 1'b0;
            bus_req_q  <= 1'b0;
            wbeat_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant_id;
                        cur_tag    <= '{id: grant_id, slot: alloc_slot[grant_id]};
                        cur_addr   <= req_addr[grant_id] & LINE_MASK;
                        cur_write  <= req_write[grant_id];
                        bus_req_q  <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_reqack) begin
                        wbeat_cnt <= '0;
                        if (cur_write) begin
                            state <= WDATA;
                        end else begin
                            state     <= IDLE;
                            bus_req_q <= 1'b0;
                        end
                    end
                end
                WDATA: begin
                    if (bus_reqack) begin
                        wbeat_cnt <= wbeat_cnt + 1'b1;
                        if (wbeat_cnt == LAST_BEAT) begin
                            state     <= IDLE;
                            bus_req_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_wdata     = !reset && state == WDATA;
    assign bus_req      = bus_req_q & ~reset;
    assign bus_reqtag   = reset ? '0 : cur_tag;
    assign bus_reqaddr  = reset ? '0 : cur_addr;
    assign bus_reqwrite = cur_write & ~reset;
    assign wbeat_idx    = reset ? '0 : wbeat_cnt;
    assign bus_reqdata  = in_wdata ? req_wdata[cur_tag.id] : '0;
    assign wbeat_ready  = {in_wdata & bus_reqack & cur_tag.id, in_wdata & bus_reqack & ~cur_tag.id};

    assign rtag = bus_resptag;

`ifdef CACHE_ARB_TAGCHECK_EN
    logic [NTAG-1:0] write_tag;
    logic            stray_q;

    assign tag_known = busy[rtag.id][rtag.slot] && !write_tag[bus_resptag];

    always_ff @(posedge clk) begin
        if (reset) begin
            write_tag <= '0;
            stray_q   <= 1'b0;
        end else begin
            if (grant_valid) begin
                write_tag[{grant_id, alloc_slot[grant_id]}] <= req_write[grant_id];
            end
            if (bus_resp && !tag_known) begin
                stray_q <= 1'b1;
            end
        end
    end

    assign err_stray = stray_q & ~reset;
`else
    assign tag_known = 1'b1;
    assign err_stray = 1'b0;
`endif

    assign resp_take      = bus_resp && !reset && tag_known;
    assign resp_last_beat = resp_take && rbeat[bus_resptag] == LAST_BEAT;
    assign bus_respack    = bus_resp & ~reset;
    assign resp_valid     = {resp_take & rtag.id, resp_take & ~rtag.id};
    assign resp_data      = resp_take ? bus_respdata : '0;
    assign resp_last      = resp_last_beat;

    // A write tag frees on its last acked beat, a fill tag on its last response beat.
    always_comb begin
        free_mask = '0;
        if (in_wdata && bus_reqack && wbeat_cnt == LAST_BEAT) begin
            free_mask[cur_tag.id][cur_tag.slot] = 1'b1;
        end
        if (resp_last_beat) begin
            free_mask[rtag.id][rtag.slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rbeat <= '0;
        end else if (resp_take) begin
            if (rbeat[bus_resptag] == LAST_BEAT) begin
                rbeat[bus_resptag] <= '0;
            end else begin
                rbeat[bus_resptag] <= rbeat[bus_resptag] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: fills, round-robin, writeback beats,
// pool exhaustion, interleaved responses, mid-transaction reset, stray tags.
module tb_cache_mem_arbiter;

    localparam int WIDTH       = 64;
    localparam int LOGLINESIZE = 3;
    localparam int TW          = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [1:0]              req_valid;
    logic [1:0]              req_write;
    logic [1:0][WIDTH-1:0]   req_addr;
    logic [1:0]              req_ready;
    logic [1:0][WIDTH-1:0]   req_wdata;
    logic [1:0]              wbeat_ready;
    logic [LOGLINESIZE-1:0]  wbeat_idx;
    logic [1:0]              resp_valid;
    logic [WIDTH-1:0]        resp_data;
    logic                    resp_last;
    logic                    bus_req;
    logic                    bus_reqack;
    logic [TW-1:0]           bus_reqtag;
    logic [WIDTH-1:0]        bus_reqaddr;
    logic                    bus_reqwrite;
    logic [WIDTH-1:0]        bus_reqdata;
    logic                    bus_resp;
    logic [TW-1:0]           bus_resptag;
    logic [WIDTH-1:0]        bus_respdata;
    logic                    bus_respack;
    logic                    err_stray;

    int checks = 0;
    int errors = 0;

    logic [1:0]    rr_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [TW-1:0] rr_tag   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};

    cache_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .req_wdata   (req_wdata),
        .wbeat_ready (wbeat_ready),
        .wbeat_idx   (wbeat_idx),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_last   (resp_last),
        .bus_req     (bus_req),
        .bus_reqack  (bus_reqack),
        .bus_reqtag  (bus_reqtag),
        .bus_reqaddr (bus_reqaddr),
        .bus_reqwrite(bus_reqwrite),
        .bus_reqdata (bus_reqdata),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respdata(bus_respdata),
        .bus_respack (bus_respack),
        .err_stray   (err_stray)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid    = 2'b00;
        req_write    = 2'b00;
        bus_reqack   = 1'b0;
        bus_resp     = 1'b0;
        bus_resptag  = '0;
        bus_respdata = '0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        idle_inputs();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        idle_inputs();
        step();
        step();
        #1;
        check("rst_bus_req", bus_req, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_err_stray", err_stray, 0);
        check("rst_reqtag", bus_reqtag, 0);
        check("rst_wbeat_idx", wbeat_idx, 0);
        reset = 1'b0;

        $display("[TB] single I-fill");
        do_reset();
        req_valid   = 2'b01;
        req_addr[0] = 64'h1000;
        #1;
        check("fill_ready", req_ready, 2'b01);
        step();
        req_valid  = 2'b00;
        bus_reqack = 1'b1;
        #1;
        check("fill_bus_req", bus_req, 1);
        check("fill_tag", bus_reqtag, 3'b000);
        check("fill_addr", bus_reqaddr, 64'h1000);
        check("fill_write", bus_reqwrite, 0);
        step();
        bus_reqack = 1'b0;
        #1;
        check("fill_bus_idle", bus_req, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            bus_resp     = 1'b1;
            bus_resptag  = 3'b000;
            bus_respdata = 64'hF000 + 64'(i);
            #1;
            check("fill_resp_valid", resp_valid, 2'b01);
            check("fill_resp_data", resp_data, 64'hF000 + 64'(i));
            check("fill_resp_last", resp_last, i == 7);
            check("fill_respack", bus_respack, 1);
        end
        step();
        bus_resp  = 1'b0;
        req_valid = 2'b01;
        #1;
        check("fill_resp_done", resp_valid, 2'b00);
        check("refill_ready", req_ready, 2'b01);
        step();
        req_valid  = 2'b00;
        bus_reqack = 1'b1;
        #1;
        check("refill_tag_reused", bus_reqtag, 3'b000);
        step();
        bus_reqack = 1'b0;

        $display("[TB] round-robin");
        do_reset();
        req_valid   = 2'b11;
        req_addr[0] = 64'h3000;
        req_addr[1] = 64'h4000;
        bus_reqack  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("rr_ready", req_ready, rr_ready[g]);
            step();
            #1;
            check("rr_tag", bus_reqtag, rr_tag[g]);
            check("rr_addr", bus_reqaddr, g[0] ? 64'h4000 : 64'h3000);
            step();
        end
        idle_inputs();

        $display("[TB] D writeback");
        do_reset();
        req_valid    = 2'b10;
        req_write    = 2'b10;
        req_addr[1]  = 64'h2045;
        req_wdata[0] = 64'hBAD0;
        req_wdata[1] = 64'hA500;
        #1;
        check("wb_ready", req_ready, 2'b10);
        step();
        req_valid  = 2'b00;
        req_write  = 2'b00;
        bus_reqack = 1'b1;
        #1;
        check("wb_bus_req", bus_req, 1);
        check("wb_addr", bus_reqaddr, 64'h2040);
        check("wb_write", bus_reqwrite, 1);
        check("wb_tag", bus_reqtag, 3'b100);
        for (int k = 0; k < 8; k++) begin
            step();
            bus_reqack   = 1'b0;
            req_wdata[1] = 64'hA500 + 64'(k);
            #1;
            check("wb_hold_req", bus_req, 1);
            check("wb_hold_idx", wbeat_idx, k);
            check("wb_hold_ready", wbeat_ready, 2'b00);
            step();
            bus_reqack = 1'b1;
            #1;
            check("wb_beat_idx", wbeat_idx, k);
            check("wb_beat_data", bus_reqdata, 64'hA500 + 64'(k));
            check("wb_beat_ready", wbeat_ready, 2'b10);
        end
        step();
        bus_reqack = 1'b0;
        req_valid  = 2'b10;
        #1;
        check("wb_done_req", bus_req, 0);
        check("wb_done_wready", wbeat_ready, 2'b00);
        check("wb_next_ready", req_ready, 2'b10);
        step();
        req_valid  = 2'b00;
        bus_reqack = 1'b1;
        #1;
        check("wb_tag_freed", bus_reqtag, 3'b100);
        step();
        bus_reqack = 1'b0;

        $display("[TB] D pool exhaustion");
        do_reset();
        req_valid   = 2'b10;
        req_addr[1] = 64'h5000;
        bus_reqack  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("full_fill_ready", req_ready, 2'b10);
            step();
            #1;
            check("full_fill_tag", bus_reqtag, {1'b1, 2'(g)});
            step();
        end
        req_valid   = 2'b11;
        req_addr[0] = 64'h6000;
        #1;
        check("full_i_wins", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        #1;
        check("full_i_tag", bus_reqtag, 3'b000);
        step();
        bus_reqack = 1'b0;
        #1;
        check("full_d_stalls", req_ready, 2'b00);
        for (int i = 0; i < 8; i++) begin
            step();
            bus_resp     = 1'b1;
            bus_resptag  = 3'b101;
            bus_respdata = 64'hE000 + 64'(i);
            #1;
            check("full_resp_valid", resp_valid, 2'b10);
            check("full_resp_last", resp_last, i == 7);
            check("full_still_stalled", req_ready, 2'b00);
        end
        step();
        bus_resp = 1'b0;
        #1;
        check("full_slot_free_ready", req_ready, 2'b10);
        step();
        req_valid  = 2'b00;
        bus_reqack = 1'b1;
        #1;
        check("full_reuse_tag", bus_reqtag, 3'b101);
        step();
        bus_reqack = 1'b0;

        $display("[TB] interleaved responses and mid-write reset");
        do_reset();
        req_valid   = 2'b10;
        req_addr[1] = 64'h8000;
        bus_reqack  = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            step();
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            step();
            bus_resp     = 1'b1;
            bus_resptag  = (i % 2 == 1) ? 3'b110 : 3'b100;
            bus_respdata = 64'hC000 + 64'(i);
            #1;
            check("il_resp_valid", resp_valid, 2'b10);
            check("il_resp_data", resp_data, 64'hC000 + 64'(i));
            check("il_resp_last", resp_last, i >= 14);
        end
        step();
        bus_resp    = 1'b0;
        req_valid   = 2'b10;
        req_write   = 2'b10;
        req_addr[1] = 64'h7000;
        #1;
        check("mid_wb_ready", req_ready, 2'b10);
        step();
        req_valid  = 2'b00;
        req_write  = 2'b00;
        bus_reqack = 1'b1;
        #1;
        check("mid_wb_tag", bus_reqtag, 3'b100);
        step();
        #1;
        check("mid_wb_idx0", wbeat_idx, 0);
        step();
        #1;
        check("mid_wb_idx1", wbeat_idx, 1);
        step();
        reset       = 1'b1;
        req_valid   = 2'b11;
        bus_resp    = 1'b1;
        bus_resptag = 3'b000;
        #1;
        check("in_rst_bus_req", bus_req, 0);
        check("in_rst_req_ready", req_ready, 0);
        check("in_rst_resp_valid", resp_valid, 0);
        check("in_rst_wbeat_ready", wbeat_ready, 0);
        check("in_rst_respack", bus_respack, 0);
        step();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("post_rst_bus_req", bus_req, 0);
        check("post_rst_wbeat_idx", wbeat_idx, 0);
        check("post_rst_tag", bus_reqtag, 0);
        check("post_rst_addr", bus_reqaddr, 0);
        check("post_rst_write", bus_reqwrite, 0);
        step();
        req_valid = 2'b11;
        #1;
        check("post_rst_i_first", req_ready, 2'b01);
        step();
        req_valid  = 2'b00;
        bus_reqack = 1'b1;
        #1;
        check("post_rst_i_tag", bus_reqtag, 3'b000);
        step();
        idle_inputs();

        $display("[TB] stray response");
        do_reset();
        bus_resp     = 1'b1;
        bus_resptag  = 3'b011;
        bus_respdata = 64'hDEAD;
        #1;
        check("stray_respack", bus_respack, 1);
`ifdef CACHE_ARB_TAGCHECK_EN
        check("stray_dropped", resp_valid, 2'b00);
        check("stray_no_last", resp_last, 0);
`else
        check("stray_routed", resp_valid, 2'b01);
`endif
        step();
        bus_resp = 1'b0;
        #1;
`ifdef CACHE_ARB_TAGCHECK_EN
        check("stray_flag_set", err_stray, 1);
`else
        check("stray_flag_tied", err_stray, 0);
`endif
        step();
        step();
        #1;
`ifdef CACHE_ARB_TAGCHECK_EN
        check("stray_flag_sticky", err_stray, 1);
`else
        check("stray_flag_still0", err_stray, 0);
`endif
        do_reset();
        #1;
        check("stray_flag_cleared", err_stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
